npu_layer_seq: RTL and testbench

NPU_LAYER_SEQ -- requirements
Module: npu_layer_seq

---
 rtl/npu_layer_seq.sv | 174 +++++++++++++++++
 tb/tb_npu_layer_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/npu_layer_seq.sv
// Layer sequencer for the NPU array: walks conv and classifier loop nests and hands one job at a time to the array.
// Define NPU_LAYER_SEQ_PERF_EN to build the busy-cycle and stall performance counters.
module npu_layer_seq #(
  parameter int W        = 8,
  parameter int C1_OFM   = 6,
  parameter int C1_TILE  = 4,
  parameter int C1_IFM   = 1,
  parameter int C2_OFM   = 16,
  parameter int C2_TILE  = 2,
  parameter int C2_IFM   = 6,
  parameter int C3_PASS  = 2,
  parameter int C3_WORD  = 16,
  parameter int FC1_PASS = 2,
  parameter int FC1_WORD = 15,
  parameter int FC2_PASS = 1,
  parameter int FC2_WORD = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  cfg_first,
  input  logic [2:0]  cfg_last,
  output logic        job_valid,
  input  logic        job_ready,
  output logic [2:0]  job_layer,
  output logic [3:0]  job_ofm,
  output logic [1:0]  job_tile,
  output logic [3:0]  job_ifm,
  output logic        job_first,
  output logic        job_last,
  input  logic        job_done,
  output logic        busy,
  output logic        done,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stall
);

  // Every loop bound must fit the 4-bit ofm/ifm and 2-bit tile fields.
  if (W < 1 || C1_OFM > 16 || C2_OFM > 16 || C1_IFM > 16 || C2_IFM > 16 ||
      C1_TILE > 4 || C2_TILE > 4 || C3_WORD > 16 || FC1_WORD > 16 || FC2_WORD > 16 ||
      C3_PASS > 16 || FC1_PASS > 16 || FC2_PASS > 16) begin : g_bad_params
    $error("npu_layer_seq: loop bound does not fit job field");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  state_t      state, state_nxt;
  logic [2:0]  layer, last_q;
  logic [3:0]  ofm, ifm;
  logic [1:0]  tile;
  logic [4:0]  ofm_b, tile_b, ifm_b;
  logic [2:0]  cf, cl;
  logic        ifm_end, tile_end, ofm_end, layer_end, run_end;

  always_comb begin
    ofm_b  = 5'd1;
    tile_b = 5'd1;
    ifm_b  = 5'd1;
    case (layer)
      3'd0: begin ofm_b = 5'(C1_OFM);   tile_b = 5'(C1_TILE); ifm_b = 5'(C1_IFM);   end
      3'd1: begin ofm_b = 5'(C2_OFM);   tile_b = 5'(C2_TILE); ifm_b = 5'(C2_IFM);   end
      3'd2: begin ofm_b = 5'(C3_PASS);  ifm_b  = 5'(C3_WORD);  end
      3'd3: begin ofm_b = 5'(FC1_PASS); ifm_b  = 5'(FC1_WORD); end
      default: begin ofm_b = 5'(FC2_PASS); ifm_b = 5'(FC2_WORD); end
    endcase
  end

  assign ifm_end   = ({1'b0, ifm}  == ifm_b  - 5'd1);
  assign tile_end  = ({3'b0, tile} == tile_b - 5'd1);
  assign ofm_end   = ({1'b0, ofm}  == ofm_b  - 5'd1);
  assign layer_end = (layer == last_q);
  assign run_end   = ifm_end && tile_end && ofm_end && layer_end;

  // Out-of-range layer indices collapse onto FC2, and an inverted range runs just the first layer.
  always_comb begin
    cf = (cfg_first > 3'd4) ? 3'd4 : cfg_first;
    cl = (cfg_last  > 3'd4) ? 3'd4 : cfg_last;
    if (cl < cf) cl = cf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (job_ready) state_nxt = WAIT;
      WAIT:    if (job_done) state_nxt = run_end ? FIN : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Loop counters advance only on a completion seen in WAIT, carrying ifm into tile, ofm and layer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer  <= '0;
      last_q <= '0;
      ofm    <= '0;
      tile   <= '0;
      ifm    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            layer  <= cf;
            last_q <= cl;
            ofm    <= '0;
            tile   <= '0;
            ifm    <= '0;
          end
        end
        WAIT: begin
          if (job_done) begin
            if (ifm_end) begin
              ifm <= '0;
              if (tile_end) begin
                tile <= '0;
                if (ofm_end) begin
                  ofm <= '0;
                  if (!layer_end) layer <= layer + 3'd1;
                end else begin
                  ofm <= ofm + 4'd1;
                end
              end else begin
                tile <= tile + 2'd1;
              end
            end else begin
              ifm <= ifm + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign job_valid = (state == ISSUE);
  assign job_layer = layer;
  assign job_ofm   = ofm;
  assign job_tile  = tile;
  assign job_ifm   = ifm;
  assign job_first = job_valid && (ifm == 4'd0);
  assign job_last  = job_valid && ifm_end;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

`ifdef NPU_LAYER_SEQ_PERF_EN
  logic [31:0] cyc_q, stall_q;

  // Both counters restart with each accepted run and freeze once the sequencer is idle again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else if (state == IDLE && start) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (busy && cyc_q != 32'hFFFF_FFFF) cyc_q <= cyc_q + 32'd1;
      if (job_valid && !job_ready && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_stall  = stall_q;
`else
  assign perf_cycles = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_npu_layer_seq.sv
// Scoreboard bench for npu_layer_seq: a loop-nest model fills a queue of expected jobs, each offered job is compared to its head.
module tb_npu_layer_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  cfg_first = '0;
  logic [2:0]  cfg_last = '0;
  logic        job_valid;
  logic        job_ready = 1'b0;
  logic [2:0]  job_layer;
  logic [3:0]  job_ofm;
  logic [1:0]  job_tile;
  logic [3:0]  job_ifm;
  logic        job_first;
  logic        job_last;
  logic        job_done = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] perf_cycles;
  logic [31:0] perf_stall;

  int assert_count = 0;
  int fail_count = 0;
  logic [14:0] exp_q[$];
  int ofm_bound[5]  = '{6, 16, 2, 2, 1};
  int tile_bound[5] = '{4, 2, 1, 1, 1};
  int ifm_bound[5]  = '{1, 6, 16, 15, 11};
  int got;

  npu_layer_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_first(cfg_first), .cfg_last(cfg_last),
    .job_valid(job_valid), .job_ready(job_ready), .job_layer(job_layer), .job_ofm(job_ofm),
    .job_tile(job_tile), .job_ifm(job_ifm), .job_first(job_first), .job_last(job_last),
    .job_done(job_done), .busy(busy), .done(done), .perf_cycles(perf_cycles), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [14:0] job_fields();
    return {job_layer, job_ofm, job_tile, job_ifm, job_first, job_last};
  endfunction

  task automatic pushExpected(input int f, input int l);
    if (f > 4) f = 4;
    if (l > 4) l = 4;
    if (l < f) l = f;
    for (int ly = f; ly <= l; ly++)
      for (int o = 0; o < ofm_bound[ly]; o++)
        for (int t = 0; t < tile_bound[ly]; t++)
          for (int i = 0; i < ifm_bound[ly]; i++)
            exp_q.push_back({3'(ly), 4'(o), 2'(t), 4'(i), i == 0, i == ifm_bound[ly] - 1});
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [2:0] l);
    exp_q.delete();
    pushExpected(int'(f), int'(l));
    @(negedge clk);
    cfg_first = f;
    cfg_last = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busyAfterStart", {31'b0, busy}, 32'd1);
  endtask

  // mode 0: always ready, 1: random stalls, 2: two stall cycles per job
  task automatic runJobs(input int n, input int mode, input bit chaos, input bit hold_last, output int cnt);
    int cyc = 0;
    int stall_cnt = 0;
    bit r;
    cnt = 0;
    while (cnt < n && cyc < 20000) begin
      job_done = 1'b0;
      if (job_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpectedJob", {31'b0, job_valid}, 32'd0);
          break;
        end
        checkOutput("jobFields", {17'b0, job_fields()}, {17'b0, exp_q[0]});
        case (mode)
          0: r = 1'b1;
          1: r = ($urandom_range(0, 3) != 0);
          default: r = (stall_cnt >= 2);
        endcase
        stall_cnt++;
        job_ready = r;
        if (!r && chaos) job_done = 1'b1;
        if (r) begin
          void'(exp_q.pop_front());
          cnt++;
          stall_cnt = 0;
          if (chaos) begin
            job_done = 1'b1;
            start = 1'b1;
          end
          @(negedge clk);
          job_ready = 1'b0;
          job_done = 1'b0;
          start = 1'b0;
          if (hold_last && cnt == n) break;
          repeat (2) @(negedge clk);
          job_done = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    job_done = 1'b0;
    job_ready = 1'b0;
    checkOutput("jobCount", cnt, n);
  endtask

  task automatic checkFinish();
    int pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checkOutput("donePulses", pulses, 1);
    checkOutput("busyIdle", {31'b0, busy}, 32'd0);
    checkOutput("validIdle", {31'b0, job_valid}, 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Ctrl"}, {28'b0, job_valid, busy, done, job_first}, 32'd0);
    checkOutput({tag, "Last"}, {31'b0, job_last}, 32'd0);
    checkOutput({tag, "Fields"}, {19'b0, job_layer, job_ofm, job_tile, job_ifm}, 32'd0);
    checkOutput({tag, "PerfCycles"}, perf_cycles, 32'd0);
    checkOutput({tag, "PerfStall"}, perf_stall, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;

    $display("[TB] full network 0..4");
    applyStimulus(3'd0, 3'd4);
    runJobs(289, 0, 1'b0, 1'b0, got);
    checkFinish();

    $display("[TB] conv2 with random stalls");
    applyStimulus(3'd1, 3'd1);
    runJobs(192, 1, 1'b0, 1'b0, got);
    checkFinish();

    $display("[TB] inverted range 4..2");
    applyStimulus(3'd4, 3'd2);
    runJobs(11, 0, 1'b0, 1'b0, got);
    checkFinish();

    $display("[TB] clamped range 6..5");
    applyStimulus(3'd6, 3'd5);
    runJobs(11, 0, 1'b0, 1'b0, got);
    checkFinish();

    $display("[TB] spurious start and job_done while busy");
    applyStimulus(3'd2, 3'd3);
    runJobs(62, 1, 1'b1, 1'b0, got);
    checkFinish();

    $display("[TB] conv1 with two stall cycles per job");
    applyStimulus(3'd0, 3'd0);
    runJobs(24, 2, 1'b0, 1'b0, got);
    checkFinish();
`ifdef NPU_LAYER_SEQ_PERF_EN
    checkOutput("perfStall", perf_stall, 32'd48);
    checkOutput("perfCycles", perf_cycles, 32'd145);
`else
    checkOutput("perfStall", perf_stall, 32'd0);
    checkOutput("perfCycles", perf_cycles, 32'd0);
`endif

    $display("[TB] reset in the middle of conv2");
    applyStimulus(3'd0, 3'd1);
    runJobs(34, 0, 1'b0, 1'b1, got);
    rst_n = 1'b0;
    #1;
    checkResetState("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    job_done = 1'b1;
    @(negedge clk);
    job_done = 1'b0;
    @(negedge clk);
    checkOutput("staleDoneBusy", {31'b0, busy}, 32'd0);
    checkOutput("staleDoneValid", {31'b0, job_valid}, 32'd0);
    applyStimulus(3'd0, 3'd0);
    runJobs(24, 0, 1'b0, 1'b0, got);
    checkFinish();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
